// File: rtl/tranif1_switch.sv
// tranif1_switch: clocked bidirectional pass switch with strength resolution and optional charge hold
module tranif1_switch #(
    parameter bit CHARGE_HOLD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gate,
    input  logic [1:0] a_drv_val,
    input  logic [1:0] a_drv_str,
    input  logic [1:0] b_drv_val,
    input  logic [1:0] b_drv_str,
    output logic [1:0] a_val,
    output logic [1:0] a_str,
    output logic [1:0] b_val,
    output logic [1:0] b_str,
    output logic       gate_on
);
    localparam logic [1:0] L_Z = 2'b10;
    localparam logic [1:0] L_X = 2'b11;

    function automatic logic [3:0] resolve(input logic [1:0] pv, ps, qv, qs);
        return (ps > qs) ? {pv, ps} :
               (qs > ps) ? {qv, qs} :
               (ps == 2'd0) ? {L_Z, 2'd0} :
               {(pv == qv) ? pv : L_X, ps};
    endfunction

    logic       r_gate;
    logic [1:0] r_qa, r_qb;
    logic       w_g, w_a_nd, w_b_nd;
    logic [3:0] w_a, w_b, w_r, w_ra, w_rb, w_m, w_oa, w_ob;
    logic [1:0] w_ha, w_hb;

    always_comb begin
        w_g    = gate[1] ? r_gate : gate[0];
        w_a_nd = (a_drv_val == L_Z) || (a_drv_str == 2'd0);
        w_b_nd = (b_drv_val == L_Z) || (b_drv_str == 2'd0);
        w_a    = w_a_nd ? {L_Z, 2'd0} : {a_drv_val, (a_drv_str == 2'd3) ? 2'd2 : a_drv_str};
        w_b    = w_b_nd ? {L_Z, 2'd0} : {b_drv_val, (b_drv_str == 2'd3) ? 2'd2 : b_drv_str};
        w_r    = resolve(w_a[3:2], w_a[1:0], w_b[3:2], w_b[1:0]);
        w_ra   = w_g ? w_r : w_a;
        w_rb   = w_g ? w_r : w_b;
        // Connected stores share charge; an uncharged (Z) store contributes nothing
        w_m    = resolve(r_qa, (r_qa == L_Z) ? 2'd0 : 2'd1, r_qb, (r_qb == L_Z) ? 2'd0 : 2'd1);
        w_ha   = CHARGE_HOLD ? (w_g ? w_m[3:2] : r_qa) : L_Z;
        w_hb   = CHARGE_HOLD ? (w_g ? w_m[3:2] : r_qb) : L_Z;
        w_oa   = (w_ra[1:0] != 2'd0) ? w_ra : {w_ha, 2'd0};
        w_ob   = (w_rb[1:0] != 2'd0) ? w_rb : {w_hb, 2'd0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate         <= 1'b0;
            r_qa           <= L_Z;
            r_qb           <= L_Z;
            {a_val, a_str} <= {L_Z, 2'd0};
            {b_val, b_str} <= {L_Z, 2'd0};
        end else begin
            r_gate         <= w_g;
            r_qa           <= (w_ra[1:0] != 2'd0) ? w_ra[3:2] : r_qa;
            r_qb           <= (w_rb[1:0] != 2'd0) ? w_rb[3:2] : r_qb;
            {a_val, a_str} <= w_oa;
            {b_val, b_str} <= w_ob;
        end
    end

    assign gate_on = r_gate;
endmodule

// File: tb/tb_tranif1_switch.sv
// tb_tranif1_switch: directed checks of pass/isolate, strength, gate hold, reset and an inverter chain
module tb_tranif1_switch;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gate, av, as, bv, bs;
    logic [1:0] a0v, a0s, b0v, b0s, a1v, a1s, b1v, b1s, pav, pas, pbv, pbs;
    logic       on0, on1, onp;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tranif1_switch #(.CHARGE_HOLD(1'b0)) u0 (
        .clk(clk), .rst(rst), .gate(gate),
        .a_drv_val(av), .a_drv_str(as), .b_drv_val(bv), .b_drv_str(bs),
        .a_val(a0v), .a_str(a0s), .b_val(b0v), .b_str(b0s), .gate_on(on0)
    );

    tranif1_switch #(.CHARGE_HOLD(1'b1)) u1 (
        .clk(clk), .rst(rst), .gate(gate),
        .a_drv_val(av), .a_drv_str(as), .b_drv_val(bv), .b_drv_str(bs),
        .a_val(a1v), .a_str(a1s), .b_val(b1v), .b_str(b1s), .gate_on(on1)
    );

    // Pull-down stage: gated by u0's B node, ground on A, weak pull-up on B
    tranif1_switch #(.CHARGE_HOLD(1'b0)) upd (
        .clk(clk), .rst(rst), .gate(b0v),
        .a_drv_val(2'b00), .a_drv_str(2'd2), .b_drv_val(2'b01), .b_drv_str(2'd1),
        .a_val(pav), .a_str(pas), .b_val(pbv), .b_str(pbs), .gate_on(onp)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] g, input logic [1:0] a_v, a_s, b_v, b_s);
        gate = g; av = a_v; as = a_s; bv = b_v; bs = b_s;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv(2'b00, 2'b10, 2'd0, 2'b10, 2'd0);
        step;
        chk("rst_a", {a0v, a0s}, 4'h8);
        chk("rst_b", {b0v, b0s}, 4'h8);
        chk("rst_on", {3'b0, on0}, 4'h0);
        chk("rst_b_ch", {b1v, b1s}, 4'h8);
        rst = 1'b0;
        drv(2'b01, 2'b00, 2'd2, 2'b10, 2'd0);
        step;
        chk("pass0_b", {b0v, b0s}, 4'h2);
        chk("pass0_a", {a0v, a0s}, 4'h2);
        chk("pass0_on", {3'b0, on0}, 4'h1);
        gate = 2'b00;
        step;
        chk("iso0_b", {b0v, b0s}, 4'h8);
        chk("iso0_b_ch", {b1v, b1s}, 4'h0);
        chk("iso0_a", {a0v, a0s}, 4'h2);
        chk("iso0_on", {3'b0, on0}, 4'h0);
        drv(2'b01, 2'b01, 2'd2, 2'b10, 2'd0);
        step;
        chk("pass1_b", {b0v, b0s}, 4'h6);
        gate = 2'b00;
        step;
        chk("iso1_b", {b0v, b0s}, 4'h8);
        chk("iso1_b_ch", {b1v, b1s}, 4'h4);
        drv(2'b01, 2'b00, 2'd2, 2'b01, 2'd1);
        step;
        chk("prio_a", {a0v, a0s}, 4'h2);
        chk("prio_b", {b0v, b0s}, 4'h2);
        gate = 2'b00;
        step;
        chk("prio_iso_a", {a0v, a0s}, 4'h2);
        chk("prio_iso_b", {b0v, b0s}, 4'h5);
        drv(2'b01, 2'b00, 2'd2, 2'b01, 2'd3);
        step;
        chk("conf_s_a", {a0v, a0s}, 4'hE);
        chk("conf_s_b", {b0v, b0s}, 4'hE);
        drv(2'b01, 2'b00, 2'd1, 2'b01, 2'd1);
        step;
        chk("conf_w_b", {b0v, b0s}, 4'hD);
        drv(2'b01, 2'b10, 2'd2, 2'b01, 2'd1);
        step;
        chk("z_nodrive", {a0v, a0s}, 4'h5);
        drv(2'b01, 2'b01, 2'd0, 2'b00, 2'd1);
        step;
        chk("s0_nodrive", {a0v, a0s}, 4'h1);
        drv(2'b01, 2'b11, 2'd2, 2'b00, 2'd1);
        step;
        chk("x_wins", {b0v, b0s}, 4'hE);
        drv(2'b01, 2'b00, 2'd2, 2'b10, 2'd0);
        step;
        gate = 2'b11;
        step;
        chk("hold_x_on", {3'b0, on0}, 4'h1);
        chk("hold_x_b", {b0v, b0s}, 4'h2);
        drv(2'b10, 2'b01, 2'd2, 2'b10, 2'd0);
        step;
        chk("hold_z_on", {3'b0, on0}, 4'h1);
        chk("hold_z_b", {b0v, b0s}, 4'h6);
        gate = 2'b00;
        step;
        gate = 2'b11;
        step;
        chk("hold0_on", {3'b0, on0}, 4'h0);
        chk("hold0_b", {b0v, b0s}, 4'h8);
        rst = 1'b1;
        step;
        rst = 1'b0;
        gate = 2'b11;
        step;
        chk("rst_gx_on", {3'b0, on0}, 4'h0);
        drv(2'b01, 2'b10, 2'd0, 2'b01, 2'd2);
        step;
        chk("mid_a", {a0v, a0s}, 4'h6);
        chk("mid_b", {b0v, b0s}, 4'h6);
        rst = 1'b1;
        step;
        chk("mid_rst_a", {a0v, a0s}, 4'h8);
        chk("mid_rst_b", {b0v, b0s}, 4'h8);
        chk("mid_rst_on", {3'b0, on0}, 4'h0);
        step;
        chk("rst_g1_on", {3'b0, on0}, 4'h0);
        rst = 1'b0;
        drv(2'b00, 2'b10, 2'd0, 2'b10, 2'd0);
        step;
        chk("rst_clr_a_ch", {a1v, a1s}, 4'h8);
        chk("rst_clr_b_ch", {b1v, b1s}, 4'h8);
        drv(2'b01, 2'b00, 2'd2, 2'b10, 2'd0);
        step;
        chk("inv_d0_q", {b0v, b0s}, 4'h2);
        step;
        chk("inv_d0_qbar", {pbv, pbs}, 4'h5);
        av = 2'b01;
        step;
        chk("inv_d1_q", {b0v, b0s}, 4'h6);
        step;
        chk("inv_d1_qbar", {pbv, pbs}, 4'h2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tranif1_switch.md
Name: tranif1_switch

Overview:
- Synthesizable, clocked model of a bidirectional NMOS-style pass switch (tranif1 semantics) for switch-level netlist emulation.
- Connects terminal A to terminal B while the held gate is 1; isolates them while it is 0.
- Each terminal carries an encoded drive level and strength. The block resolves both sides and returns the node value seen at each terminal.
- Gate input is sampled only when it is a known 0/1. X/Z on the gate leaves the previous switch state unchanged.

Parameters:
CHARGE_HOLD, 0, 1 = an undriven terminal keeps its last resolved level at strength 0 (capacitive node); 0 = an undriven terminal reads Z

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
gate  input  2  gate level code
a_drv_val  input  2  external drive level on terminal A
a_drv_str  input  2  external drive strength on terminal A
b_drv_val  input  2  external drive level on terminal B
b_drv_str  input  2  external drive strength on terminal B
a_val  output  2  resolved level at A
a_str  output  2  resolved strength at A
b_val  output  2  resolved level at B
b_str  output  2  resolved strength at B
gate_on  output  1  held switch state

Behaviour:
- Level code: 00=0, 01=1, 10=Z, 11=X.
- Strength code: 0=none, 1=weak, 2=strong, 3=treated as strong.
- Input normalisation: a drive with level Z, or with strength 0, is "no drive" (level Z, strength 0).
- Gate hold:
  - Effective gate = gate when gate is 00 or 01; otherwise gate_hold.
  - gate_hold <= effective gate on every clk edge.
  - gate_on = gate_hold.
- Resolve(p, q):
  - Higher strength wins.
  - Equal strengths: if both are 0 -> (Z, 0); if levels equal -> that level; if levels differ -> (X, that strength).
  - An X level at the winning strength yields X.
- Connected (effective gate = 1): r = Resolve(A drive, B drive); both terminals output r.
- Isolated (effective gate = 0): each terminal outputs its own normalised drive.
- Undriven result (strength 0):
  - CHARGE_HOLD=0 -> output (Z, 0).
  - CHARGE_HOLD=1 -> output (stored level, 0). The store updates whenever the terminal's result has strength > 0. While connected, the two stores are merged with Resolve at equal strength (differ -> X).
- Timing: all outputs are registered. An input change at edge n is visible after edge n+1 (1-cycle latency). No handshake.
- Reset (rst=1 at a clk edge, overriding everything else):
  - gate_hold=0, gate_on=0.
  - Outputs = (Z, 0) on both terminals.
  - Charge stores = Z.
  - Reset mid-operation discards held gate and charge.
- Gate X/Z immediately after reset keeps the switch off.
- Simultaneous gate and drive changes take effect in the same cycle; drives are evaluated against the new effective gate.

Test Plan:
- Pass/isolate: A strong 0, B none, gate 1 -> next cycle B=(0,strong), gate_on=1. Then gate 0 -> B=(Z,0) with CHARGE_HOLD=0, or (0,0) with CHARGE_HOLD=1. Repeat with A strong 1 -> B=1.
- Strength priority: A strong 0, B weak 1, gate 1 -> A and B both (0, strong). Gate 0 -> A=(0, strong), B=(1, weak).
- Conflict: A strong 0, B strong 1, gate 1 -> A and B both (X, strong). Weak 0 vs weak 1 -> (X, weak).
- Gate hold: gate 1, then gate=X (11), then Z (10) -> gate_on stays 1 and A still drives B. Gate 0 then X -> gate_on stays 0. After reset, gate X -> gate_on=0.
- Reset mid-operation: connected with B=(1, strong), assert rst for one cycle -> all outputs (Z, 0), gate_on=0. With rst=1 and gate=1 together -> gate_on remains 0.
- Inverter chain: feed this block's B result into a second instance acting as a pull-down, with a weak-1 drive on the second instance's output node.
  - Check: d=0, en=1 -> q=0, q_bar=1 (weak).
  - Check: d=1, en=1 -> q=1, q_bar=0 (strong).
